// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter: mode encodings and Gray conversion.
package counter_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // Operates at the widest legal counter width; callers zero-extend and slice.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-state for the modulo counter: step, wrap/saturate, bounce turn, tc.
module counter_next
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] i_out,
  input  logic             i_dir,
  input  logic [1:0]       i_mode,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_next_out,
  output logic             o_next_dir,
  output logic             o_next_tc
);

  // Compare against the top value before stepping so the count never leaves range,
  // even when MODULUS fills the whole WIDTH-bit space.
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] w_term;

  always_comb begin
    w_term = MAXV;
    if (i_mode == MODE_DOWN || (i_mode == MODE_BOUNCE && !i_dir))
      w_term = '0;
  end

  always_comb begin
    o_next_out = i_out;
    o_next_dir = i_dir;
    o_next_tc  = 1'b0;
    if (i_en && i_mode != MODE_HOLD) begin
      o_next_tc = (i_out == w_term);
      case (i_mode)
        MODE_UP: begin
          if (i_out == MAXV) o_next_out = SATURATE ? i_out : '0;
          else               o_next_out = i_out + ONE;
        end
        MODE_DOWN: begin
          if (i_out == '0) o_next_out = SATURATE ? '0 : MAXV;
          else             o_next_out = i_out - ONE;
        end
        MODE_BOUNCE: begin
          if (i_dir) begin
            if (i_out == MAXV) begin
              o_next_out = MAXV - ONE;
              o_next_dir = 1'b0;
            end else begin
              o_next_out = i_out + ONE;
            end
          end else begin
            if (i_out == '0) begin
              o_next_out = ONE;
              o_next_dir = 1'b1;
            end else begin
              o_next_out = i_out - ONE;
            end
          end
        end
        default: o_next_out = i_out;
      endcase
    end
  end

endmodule

// File: rtl/counter_gen.sv
// Parametrised modulo counter with up/down/bounce/hold modes, clear, load,
// optional saturation, registered Gray output and terminal-count pulse.
module counter_gen
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_gray,
  output logic             dir,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] r_out, r_gray;
  logic             r_dir, r_tc;

  logic [WIDTH-1:0] w_step_out, w_d_out;
  logic             w_step_dir, w_step_tc, w_d_dir, w_d_tc;
  logic [31:0]      w_gray32;

  counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .i_out     (r_out),
    .i_dir     (r_dir),
    .i_mode    (mode),
    .i_en      (en),
    .o_next_out(w_step_out),
    .o_next_dir(w_step_dir),
    .o_next_tc (w_step_tc)
  );

  always_comb begin
    w_d_out = w_step_out;
    w_d_dir = w_step_dir;
    w_d_tc  = w_step_tc;
    if (clr) begin
      w_d_out = '0;
      w_d_dir = 1'b1;
      w_d_tc  = 1'b0;
    end else if (load) begin
      w_d_out = (load_val > MAXV) ? MAXV : load_val;
      w_d_dir = r_dir;
      w_d_tc  = 1'b0;
    end
  end

  // Gray is derived from the next value so it lands on the same edge as out.
  assign w_gray32 = bin2gray(32'(w_d_out));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out  <= '0;
      r_gray <= '0;
      r_dir  <= 1'b1;
      r_tc   <= 1'b0;
    end else begin
      r_out  <= w_d_out;
      r_gray <= w_gray32[WIDTH-1:0];
      r_dir  <= w_d_dir;
      r_tc   <= w_d_tc;
    end
  end

  assign out      = r_out;
  assign out_gray = r_gray;
  assign dir      = r_dir;
  assign tc       = r_tc;

endmodule

// File: tb/tb_counter_gen.sv
// Self-checking bench: five counter_gen configurations share one stimulus stream
// and are compared every cycle against an arithmetic reference model.
module tb_counter_gen;

  localparam int N = 5;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       clr = 1'b0, load = 1'b0, en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] load_val = 4'd0;

  logic [3:0] q_out[N], q_gray[N];
  logic       q_dir[N], q_tc[N];
  logic [2:0] o3, g3;

  int MODV[N] = '{10, 10, 4, 8, 2};
  int SATV[N] = '{0, 1, 0, 0, 0};
  int WV[N]   = '{4, 4, 4, 3, 4};

  int m_out[N], m_dir[N], m_tc[N];
  int n_chk = 0, n_err = 0;

  always #5 CLK = ~CLK;

  counter_gen #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u0 (
    .CLK(CLK), .RST(RST), .clr(clr), .load(load), .load_val(load_val), .en(en), .mode(mode),
    .out(q_out[0]), .out_gray(q_gray[0]), .dir(q_dir[0]), .tc(q_tc[0]));
  counter_gen #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u1 (
    .CLK(CLK), .RST(RST), .clr(clr), .load(load), .load_val(load_val), .en(en), .mode(mode),
    .out(q_out[1]), .out_gray(q_gray[1]), .dir(q_dir[1]), .tc(q_tc[1]));
  counter_gen #(.WIDTH(4), .MODULUS(4), .SATURATE(1'b0)) u2 (
    .CLK(CLK), .RST(RST), .clr(clr), .load(load), .load_val(load_val), .en(en), .mode(mode),
    .out(q_out[2]), .out_gray(q_gray[2]), .dir(q_dir[2]), .tc(q_tc[2]));
  counter_gen #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u3 (
    .CLK(CLK), .RST(RST), .clr(clr), .load(load), .load_val(load_val[2:0]), .en(en), .mode(mode),
    .out(o3), .out_gray(g3), .dir(q_dir[3]), .tc(q_tc[3]));
  counter_gen #(.WIDTH(4), .MODULUS(2), .SATURATE(1'b0)) u4 (
    .CLK(CLK), .RST(RST), .clr(clr), .load(load), .load_val(load_val), .en(en), .mode(mode),
    .out(q_out[4]), .out_gray(q_gray[4]), .dir(q_dir[4]), .tc(q_tc[4]));

  assign q_out[3]  = {1'b0, o3};
  assign q_gray[3] = {1'b0, g3};

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_out[i] = 0; m_dir[i] = 1; m_tc[i] = 0;
    end
  endtask

  // Behavioural rules: clear beats load beats an enabled step; anything else holds.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int top, lv, term;
      top = MODV[i] - 1;
      lv  = int'(load_val) & ((1 << WV[i]) - 1);
      if (clr) begin
        m_out[i] = 0; m_dir[i] = 1; m_tc[i] = 0;
      end else if (load) begin
        m_out[i] = (lv > top) ? top : lv;
        m_tc[i]  = 0;
      end else if (en && mode != 2'b11) begin
        if (mode == 2'b01 || (mode == 2'b10 && m_dir[i] == 0)) term = 0;
        else term = top;
        m_tc[i] = (m_out[i] == term) ? 1 : 0;
        if (mode == 2'b00) begin
          if (m_out[i] == top) m_out[i] = SATV[i] ? top : 0;
          else m_out[i] = m_out[i] + 1;
        end else if (mode == 2'b01) begin
          if (m_out[i] == 0) m_out[i] = SATV[i] ? 0 : top;
          else m_out[i] = m_out[i] - 1;
        end else if (m_dir[i] == 1) begin
          if (m_out[i] == top) begin m_out[i] = top - 1; m_dir[i] = 0; end
          else m_out[i] = m_out[i] + 1;
        end else begin
          if (m_out[i] == 0) begin m_out[i] = 1; m_dir[i] = 1; end
          else m_out[i] = m_out[i] - 1;
        end
      end else begin
        m_tc[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_u%0d_out", ph, i), q_out[i], m_out[i]);
      check($sformatf("%s_u%0d_gray", ph, i), q_gray[i], m_out[i] ^ (m_out[i] >> 1));
      check($sformatf("%s_u%0d_dir", ph, i), q_dir[i], m_dir[i]);
      check($sformatf("%s_u%0d_tc", ph, i), q_tc[i], m_tc[i]);
    end
  endtask

  task automatic tick(input string ph);
    @(posedge CLK);
    model_step();
    #1;
    check_all(ph);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b1; en = 1'b1; mode = 2'b00;

    for (int k = 1; k <= 12; k++) begin
      tick("p1_up");
      if (k == 9)  check("p1_gray_at9", q_gray[0], 4'b1101);
      if (k == 10) check("p1_tc_wrap", q_tc[0], 1);
    end

    clr = 1'b1; tick("p2_clr"); clr = 1'b0;
    mode = 2'b01;
    for (int k = 0; k < 3; k++) tick("p2_down");
    #3 RST = 1'b0;
    #1;
    model_reset();
    check_all("p2_async");
    check("p2_async_out", q_out[0], 0);
    @(negedge CLK);
    RST = 1'b1;

    mode = 2'b00; load = 1'b1; load_val = 4'd8;
    tick("p3_load"); load = 1'b0;
    for (int k = 0; k < 3; k++) tick("p3_sat_up");
    check("p3_sat_hold", q_out[1], 9);
    clr = 1'b1; tick("p3_clr"); clr = 1'b0;
    mode = 2'b01;
    tick("p3_sat_down"); tick("p3_sat_down");
    check("p3_sat_tc", q_tc[1], 1);

    clr = 1'b1; tick("p4_clr"); clr = 1'b0;
    mode = 2'b10;
    for (int k = 0; k < 8; k++) tick("p4_bounce");

    load = 1'b1; load_val = 4'd15;
    tick("p5_clamp");
    check("p5_clamp_out", q_out[0], 9);
    clr = 1'b1; en = 1'b1;
    tick("p5_clr_wins");
    clr = 1'b0; load = 1'b0;

    mode = 2'b00; load = 1'b1; load_val = 4'd5;
    tick("p6_load"); load = 1'b0;
    en = 1'b1; tick("p6_en");
    en = 1'b0; tick("p6_en");
    en = 1'b1; tick("p6_en");
    mode = 2'b11; tick("p6_hold"); tick("p6_hold");
    check("p6_hold_out", q_out[0], 7);

    for (int k = 0; k < 400; k++) begin
      clr      = ($urandom % 20) == 0;
      load     = ($urandom % 12) == 0;
      en       = ($urandom % 5) != 0;
      mode     = 2'($urandom % 4);
      load_val = 4'($urandom % 16);
      tick("rand");
      if (k == 200) begin
        #2 RST = 1'b0;
        #1;
        model_reset();
        check_all("rand_async");
        @(negedge CLK);
        RST = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/counter_gen.md
Name: counter_gen

Overview:
Parametrised modulo counter. It generalises the fixed 4-bit free-running counter to any width and modulus, and adds:
- selectable count mode: up, down, bounce or hold
- enable, synchronous clear and parallel load
- optional saturation
- a Gray-coded output and a terminal-count pulse

It sits as a timing and sequence source driven by the system clock, and feeds display, sequencing and test logic.

Parameters:
WIDTH, 4, counter width in bits; range 2..32.
MODULUS, 16, count range is 0..MODULUS-1; requires 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 1 = up/down modes stop at the limit instead of wrapping; ignored in bounce mode.

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
RST  input  1  asynchronous, active-low reset.
clr  input  1  synchronous clear; highest priority after reset.
load  input  1  synchronous parallel load.
load_val  input  WIDTH  value to load.
en  input  1  count enable.
mode  input  2  00 up, 01 down, 10 bounce, 11 hold.
out  output  WIDTH  registered binary count.
out_gray  output  WIDTH  registered Gray code of out; changes on the same edge as out.
dir  output  1  registered bounce direction; 1 = up.
tc  output  1  registered terminal-count pulse.

Behaviour:
- Reset (RST=0, asynchronous): out=0, out_gray=0, dir=1, tc=0. These values hold while RST=0. Release takes effect at the next rising edge.
- Per-edge priority: clr > load > (en and mode != hold) > hold.
- clr: out=0, out_gray=0, dir=1, tc=0.
- load:
  - out = load_val if load_val <= MODULUS-1, else MODULUS-1 (clamped).
  - tc=0; dir unchanged.
- Terminal value T: MODULUS-1 for up; 0 for down; in bounce, MODULUS-1 when dir=1 and 0 when dir=0.
- Step with en=1:
  - up: out<T gives out+1. out==T gives 0, or stays T if SATURATE=1.
  - down: out>0 gives out-1. out==0 gives MODULUS-1, or stays 0 if SATURATE=1.
  - bounce, dir=1: out<MODULUS-1 gives out+1. At MODULUS-1: out=MODULUS-2, dir=0.
  - bounce, dir=0: out>0 gives out-1. At 0: out=1, dir=1.
  - MODULUS=2 bounce toggles 0,1,0,1 with dir flipping at each end.
- tc:
  - Set to 1 on the edge of any enabled step taken while out==T; that covers a wrap, a saturated hold or a bounce turn.
  - Otherwise cleared to 0.
  - Under saturation with en held, tc stays 1 on every cycle.
  - en=0 or mode=hold: out and dir hold, tc=0.
- Latency: out, out_gray, dir and tc all update on the same edge as the triggering inputs; there is no combinational input-to-output path.
- Mode change mid-count: takes effect at the next edge from the current out.
  - dir is kept when switching into bounce.
  - dir is ignored (and held) in the other modes.
- Arithmetic: all compare and add is done at WIDTH bits. The modulus compare is made against MODULUS-1 before increment, so out never leaves 0..MODULUS-1. This holds even when MODULUS=2**WIDTH.
- out_gray = next_out ^ (next_out >> 1), registered. It must never reflect a stale out.

Decomposition:
- Shared package counter_pkg holds:
  - mode localparams MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_BOUNCE=2'b10, MODE_HOLD=2'b11
  - function bin2gray(WIDTH-generic)
- Optional sub-module counter_next: combinational next-state, computing next_out, next_dir and next_tc from out, dir, mode and en.
- The top level holds only the registers, the reset and the clr/load priority.

Test Plan:
1. WIDTH=4, MODULUS=10, SATURATE=0, mode=up, en=1 after reset, 12 cycles -> out 1..9,0,1,2; tc=1 only on the cycle out becomes 0; out_gray on the 9 cycle=4'b1101.
2. Same config, mode=down from 0, 3 cycles -> out 9,8,7; tc=1 with out=9. Then assert RST=0 mid-count -> out=0, tc=0 immediately, without waiting for CLK.
3. SATURATE=1, mode=up, load_val=8, then en=1 for 3 cycles -> out 8,9,9,9; tc=0,0,1,1. Then mode=down from 0 -> out stays 0, tc=1.
4. mode=bounce, MODULUS=4, from reset, 8 cycles -> out 1,2,3,2,1,0,1,2; dir goes 0 on the cycle out=2 after 3 and 1 on the cycle out=1 after 0; tc=1 on those two cycles.
5. load_val=15 with MODULUS=10 -> out=9, tc=0. Then clr=1, load=1 and en=1 together -> out=0, dir=1 (clr wins).
6. en toggling 1,0,1 and mode=hold for 2 cycles during up count from 5 -> out 6,6,7,7,7; tc=0 throughout.
